// File: rtl/multi_channel_wave_nco.sv
// Multi-channel phase-accumulator waveform generator.
// Shared byte-writable lookup table, optional quarter-wave folding.
module multi_channel_wave_nco #(
    parameter int NCH     = 2,
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         enable,
    input  logic [NCH-1:0]         preload,
    input  logic [NCH-1:0]         updn,
    input  logic [NCH*PHASE_W-1:0] pl_data,
    input  logic [NCH*PHASE_W-1:0] incr,
    input  logic                   quarter,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W/8-1:0]    wr_mask,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [NCH*DATA_W-1:0]  dout,
    output logic [NCH-1:0]         dout_vld
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int KW    = ADDR_W - 2;

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = ~MOST_NEG;

    logic [DATA_W-1:0] lut [DEPTH];

    // Table has no reset; contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_mask[b]) begin
                    lut[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PHASE_W-1:0] pl;
        logic [PHASE_W-1:0] inc;
        logic [PHASE_W-1:0] phase;
        logic               v0;
        logic [ADDR_W-1:0]  idx;
        logic [KW-1:0]      k;
        logic [ADDR_W-1:0]  rd_addr;
        logic [DATA_W-1:0]  s1_data;
        logic               s1_quarter;
        logic               s1_neg;
        logic               v1;
        logic [DATA_W-1:0]  folded;
        logic [DATA_W-1:0]  dout_r;
        logic               vld_r;

        assign pl  = pl_data[c*PHASE_W +: PHASE_W];
        assign inc = incr[c*PHASE_W +: PHASE_W];

        if (PHASE_W >= ADDR_W) begin : g_idx
            assign idx = phase[PHASE_W-1 -: ADDR_W];
        end else begin : g_idx
            assign idx = {{(ADDR_W-PHASE_W){1'b0}}, phase};
        end

        assign k = idx[KW-1:0];
        // Odd quadrants walk the first quarter backwards.
        assign rd_addr = quarter ? {2'b00, idx[ADDR_W-2] ? ~k : k} : idx;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase <= '0;
                v0    <= 1'b0;
            end else begin
                if (preload[c]) begin
                    phase <= pl;
                end else if (enable[c]) begin
                    phase <= updn[c] ? phase + inc : phase - inc;
                end
                v0 <= preload[c] | enable[c];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_data    <= '0;
                s1_quarter <= 1'b0;
                s1_neg     <= 1'b0;
                v1         <= 1'b0;
            end else begin
                s1_data    <= lut[rd_addr];
                s1_quarter <= quarter;
                s1_neg     <= idx[ADDR_W-1];
                v1         <= v0;
            end
        end

        always_comb begin
            folded = s1_data;
            if (s1_quarter && s1_neg) begin
                folded = (s1_data == MOST_NEG) ? MOST_POS : -s1_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_r <= '0;
                vld_r  <= 1'b0;
            end else begin
                if (v1) begin
                    dout_r <= folded;
                end
                vld_r <= v1;
            end
        end

        assign dout[c*DATA_W +: DATA_W] = dout_r;
        assign dout_vld[c]              = vld_r;
    end

endmodule

// File: tb/tb_multi_channel_wave_nco.sv
// Directed self-checking bench for multi_channel_wave_nco.
// Two channels, 16-bit phase, 256 x 32-bit table.
module tb_multi_channel_wave_nco;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  enable;
    logic [1:0]  preload;
    logic [1:0]  updn;
    logic [31:0] pl_data;
    logic [31:0] incr;
    logic        quarter;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic [63:0] dout;
    logic [1:0]  dout_vld;

    int n_checks = 0;
    int n_fail   = 0;

    multi_channel_wave_nco #(
        .NCH(2), .PHASE_W(16), .ADDR_W(8), .DATA_W(32)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .preload(preload),
        .updn(updn), .pl_data(pl_data), .incr(incr), .quarter(quarter),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .dout(dout), .dout_vld(dout_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        wr_en = 1'b0; wr_mask = 4'h0;
    endtask

    // One control edge, then wait until its sample lands on dout.
    task automatic issue(input logic [1:0] pre, input logic [1:0] en);
        preload = pre; enable = en;
        tick();
        preload = 2'b00; enable = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 0; preload = 0; updn = 2'b11;
        pl_data = 0; incr = 0; quarter = 0;
        wr_en = 0; wr_addr = 0; wr_mask = 0; wr_data = 0;
        tick(); tick();
        n_checks++;
        if (dout !== 64'h0 || dout_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state dout=%h vld=%b want 0/00", dout, dout_vld);
        end
        reset = 1'b0;
        for (int i = 0; i < 256; i++) wr(8'(i), 32'(i), 4'hF);
        n_checks++;
        if (dout_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_vld got=%b want 00", dout_vld);
        end
        incr[15:0] = 16'h0100; pl_data[15:0] = 16'h0000;
        preload = 2'b01;
        tick();
        preload = 2'b00; enable = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (dout[31:0] !== 32'(i) || dout_vld !== 2'b01) begin
                n_fail++;
                $display("FAIL ramp[%0d] dout=%h vld=%b want %h/01",
                         i, dout[31:0], dout_vld, i);
            end
        end
        enable = 2'b00;
        tick(); tick(); tick();
        n_checks++;
        if (dout[31:0] !== 32'd6 || dout_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL ramp_tail dout=%h vld=%b want 6/00",
                     dout[31:0], dout_vld);
        end
    endtask

    task automatic test_wrap();
        pl_data[15:0] = 16'hFF00;
        issue(2'b01, 2'b00);
        n_checks++;
        if (dout[31:0] !== 32'hFF || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL wrap_pre dout=%h vld=%b want ff/01", dout[31:0], dout_vld);
        end
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'h0 || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL wrap_up dout=%h vld=%b want 0/01", dout[31:0], dout_vld);
        end
        updn[0] = 1'b0; pl_data[15:0] = 16'h0000;
        issue(2'b01, 2'b00);
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'hFF || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL wrap_down dout=%h vld=%b want ff/01", dout[31:0], dout_vld);
        end
        incr[15:0] = 16'h0000;
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'hFF || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_incr dout=%h vld=%b want ff/01", dout[31:0], dout_vld);
        end
        tick();
        n_checks++;
        if (dout_vld !== 2'b00 || dout[31:0] !== 32'hFF) begin
            n_fail++;
            $display("FAIL vld_strobe vld=%b dout=%h want 00/ff", dout_vld, dout[31:0]);
        end
        updn[0] = 1'b1;
    endtask

    task automatic test_quarter();
        logic [15:0] ph [4];
        logic [31:0] ex [4];
        ph = '{16'h0500, 16'h4500, 16'h8500, 16'hC500};
        ex = '{32'd1005, 32'd1058, 32'hFFFF_FC13, 32'hFFFF_FBDE};
        for (int i = 0; i < 64; i++) wr(8'(i), 32'(1000 + i), 4'hF);
        quarter = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl_data[15:0] = ph[i];
            issue(2'b01, 2'b00);
            n_checks++;
            if (dout[31:0] !== ex[i] || dout_vld !== 2'b01) begin
                n_fail++;
                $display("FAIL quarter[%0d] dout=%h want %h", i, dout[31:0], ex[i]);
            end
        end
        wr(8'h00, 32'h8000_0000, 4'hF);
        pl_data[15:0] = 16'h8000;
        issue(2'b01, 2'b00);
        n_checks++;
        if (dout[31:0] !== 32'h7FFF_FFFF) begin
            n_fail++;
            $display("FAIL quarter_sat dout=%h want 7fffffff", dout[31:0]);
        end
        pl_data[15:0] = 16'h8500;
        preload = 2'b01;
        tick();
        preload = 2'b00;
        tick();
        quarter = 1'b0;
        tick();
        n_checks++;
        if (dout[31:0] !== 32'hFFFF_FC13) begin
            n_fail++;
            $display("FAIL quarter_inflight dout=%h want fffffc13", dout[31:0]);
        end
        issue(2'b01, 2'b00);
        n_checks++;
        if (dout[31:0] !== 32'h85) begin
            n_fail++;
            $display("FAIL full_mode dout=%h want 85", dout[31:0]);
        end
    endtask

    task automatic test_write();
        wr(8'h20, 32'h1122_3344, 4'hF);
        pl_data[15:0] = 16'h2000;
        preload = 2'b01;
        tick();
        preload = 2'b00;
        wr(8'h20, 32'hAABB_CCDD, 4'b0011);
        tick();
        n_checks++;
        if (dout[31:0] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL rd_before_wr dout=%h want 11223344", dout[31:0]);
        end
        incr[15:0] = 16'h0000;
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'h1122_CCDD) begin
            n_fail++;
            $display("FAIL byte_mask dout=%h want 1122ccdd", dout[31:0]);
        end
    endtask

    task automatic test_multi_channel();
        logic [31:0] e0 [6];
        logic [31:0] e1 [6];
        e0 = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
        e1 = '{32'h80, 32'h7D, 32'h7A, 32'hA0, 32'h9D, 32'h9A};
        incr = {16'h0300, 16'h0100};
        updn = 2'b01;
        for (int k = 0; k < 8; k++) begin
            preload = (k == 0) ? 2'b11 : (k == 3) ? 2'b10 : 2'b00;
            enable  = (k >= 1 && k <= 5) ? 2'b11 : 2'b00;
            pl_data = {(k == 3) ? 16'hA000 : 16'h8000, 16'h4000};
            tick();
            if (k >= 2) begin
                n_checks++;
                if (dout[31:0] !== e0[k-2] || dout[63:32] !== e1[k-2]
                    || dout_vld !== 2'b11) begin
                    n_fail++;
                    $display("FAIL multi[%0d] ch0=%h ch1=%h vld=%b want %h %h 11",
                             k - 2, dout[31:0], dout[63:32], dout_vld,
                             e0[k-2], e1[k-2]);
                end
            end
        end
        preload = 2'b00; enable = 2'b00;
        tick();
        n_checks++;
        if (dout_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL multi_tail vld=%b want 00", dout_vld);
        end
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'h46 || dout[63:32] !== 32'h9A || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL indep ch0=%h ch1=%h vld=%b want 46 9a 01",
                     dout[31:0], dout[63:32], dout_vld);
        end
    endtask

    task automatic test_reset_mid_run();
        enable = 2'b01;
        tick(); tick();
        enable = 2'b00;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dout !== 64'h0 || dout_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset dout=%h vld=%b want 0/00", dout, dout_vld);
        end
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dout_vld !== 2'b00 || dout !== 64'h0) begin
                n_fail++;
                $display("FAIL stale[%0d] vld=%b dout=%h want 00/0", i, dout_vld, dout);
            end
        end
        incr = 32'h0;
        issue(2'b00, 2'b01);
        n_checks++;
        if (dout[31:0] !== 32'h8000_0000 || dout_vld !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset dout=%h vld=%b want 80000000/01",
                     dout[31:0], dout_vld);
        end
        pl_data[15:0] = 16'h2000;
        issue(2'b01, 2'b00);
        n_checks++;
        if (dout[31:0] !== 32'h1122_CCDD) begin
            n_fail++;
            $display("FAIL table_kept dout=%h want 1122ccdd", dout[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_quarter();
        test_write();
        test_multi_channel();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
